// File: rtl/seq_multiplier_8bit.sv
// Shift-and-add multiplier: start accepted in IDLE, product and a one-cycle done pulse WIDTH edges later.
// No backpressure; start is ignored while busy. Optional two's-complement mode via SIGNED_MULT_EN.
module seq_multiplier_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      count;
  logic               last_iter;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   mq_shift;
  logic [2*WIDTH-1:0] raw_product;
  logic [2*WIDTH-1:0] final_product;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

`ifdef SIGNED_MULT_EN
  logic sign;

  // Magnitudes go through the unsigned datapath; the most negative value maps to 2^(WIDTH-1).
  assign op_a          = a[WIDTH-1] ? -a : a;
  assign op_b          = b[WIDTH-1] ? -b : b;
  assign final_product = sign ? -raw_product : raw_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
    end else if (state == IDLE && start) begin
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign op_a          = a;
  assign op_b          = b;
  assign final_product = raw_product;
`endif

  // The add carries into bit WIDTH, which is shifted straight back into the accumulator MSB.
  assign sum         = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign acc_shift   = sum[WIDTH:1];
  assign mq_shift    = {sum[0], mq[WIDTH-1:1]};
  assign raw_product = {acc_shift, mq_shift};
  assign last_iter   = (count == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            mq    <= op_b;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shift;
          mq    <= mq_shift;
          count <= count + CW'(1);
          if (last_iter) product <= final_product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Directed and random bench for seq_multiplier_8bit with an arithmetic reference model.
module tb_seq_multiplier_8bit;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int vectors;
  int miscompares;
  logic [2*WIDTH-1:0] last_product;

  seq_multiplier_8bit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int px;
    int py;
`ifdef SIGNED_MULT_EN
    px = int'($signed(x));
    py = int'($signed(y));
`else
    px = int'(x);
    py = int'(y);
`endif
    return (2*WIDTH)'(px * py);
  endfunction

  task automatic check(input string tag, input logic [2*WIDTH-1:0] obs, input logic [2*WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start pulse, then checks on every cycle through the return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] exp;
    exp   = ref_mul(x, y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    for (int k = 1; k < WIDTH; k++) begin
      check("run_busy", 16'(busy), 16'(1));
      check("run_done", 16'(done), 16'(0));
      check("run_hold_product", product, last_product);
      start = 1'(k[0]);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      tick();
    end
    check("last_run_busy", 16'(busy), 16'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_pulse", 16'(done), 16'(1));
    check("done_busy", 16'(busy), 16'(0));
    check("product", product, exp);
    tick();
    check("after_done", 16'(done), 16'(0));
    check("after_busy", 16'(busy), 16'(0));
    check("product_hold", product, exp);
    last_product = exp;
  endtask

  initial begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y2;
    vectors      = 0;
    miscompares  = 0;
    last_product = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_busy", 16'(busy), 16'(0));
    check("reset_done", 16'(done), 16'(0));
    check("reset_product", product, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 16'(busy), 16'(0));

    run_op(8'd13, 8'd11);
    check("dir_13x11", product, 16'h008F);
    run_op(8'd255, 8'd255);
    run_op(8'd0, 8'd200);
    run_op(8'd200, 8'd0);
    run_op(8'd1, 8'd128);
    run_op(8'hFD, 8'd5);
    run_op(8'h80, 8'h80);
    run_op(8'd7, 8'hFF);
    run_op(8'h7F, 8'h81);

    for (int i = 0; i < 30; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom));
    end

    // start held high with operands toggling: the second op begins two cycles after done.
    x     = WIDTH'($urandom);
    y     = WIDTH'($urandom);
    x2    = WIDTH'($urandom);
    y2    = WIDTH'($urandom);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    for (int k = 1; k <= WIDTH; k++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      tick();
    end
    check("held_done", 16'(done), 16'(1));
    check("held_product", product, ref_mul(x, y));
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    tick();
    check("held_idle_done", 16'(done), 16'(0));
    check("held_idle_busy", 16'(busy), 16'(0));
    a = x2;
    b = y2;
    tick();
    check("held_restart_busy", 16'(busy), 16'(1));
    for (int k = 1; k <= WIDTH; k++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      tick();
    end
    start = 1'b0;
    check("held2_done", 16'(done), 16'(1));
    check("held2_product", product, ref_mul(x2, y2));
    tick();
    last_product = ref_mul(x2, y2);

    run_op(8'd13, 8'd11);

    // Reset abort four iterations into a run.
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_abort_busy", 16'(busy), 16'(1));
    check("pre_abort_product", product, 16'h008F);
    rst_n = 1'b0;
    #1;
    check("abort_product", product, 16'h0000);
    check("abort_busy", 16'(busy), 16'(0));
    check("abort_done", 16'(done), 16'(0));
    tick();
    rst_n = 1'b1;
    last_product = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_done", 16'(done), 16'(0));
      check("abort_idle_busy", 16'(busy), 16'(0));
    end
    run_op(8'd37, 8'd91);

    // Product stability in IDLE with start low and inputs wandering.
    for (int k = 0; k < 20; k++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      tick();
      check("stable_product", product, last_product);
      check("stable_done", 16'(done), 16'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_8bit.md
Name: seq_multiplier_8bit

Overview:
- Sequential shift-and-add unsigned multiplier for the ALU's MUL operation.
- Built from the codebase's clocked storage stages: accumulator register A, multiplier shift register Q, multiplicand register M, and a 3-bit iteration counter.
- Sits between the operand registers (upstream) and the ALU result register (downstream).
- Takes WIDTH iterations per product and uses a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits. Product is 2*WIDTH. Counter width is clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiplication; sampled only in IDLE
- a  in  WIDTH  multiplicand; captured on the accepted start edge
- b  in  WIDTH  multiplier; captured on the accepted start edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  registered result; holds until the next result is written

Behaviour:
- Reset: clk and a single asynchronous active-low reset rst_n. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, A=0, Q=0, M=0, carry=0, count=0.
- Reset mid-RUN aborts immediately. No done pulse is issued. product returns to 0.
- FSM states:
  - IDLE: on a clk edge with start=1: M<=a, Q<=b, A<=0, carry<=0, count<=0, go to RUN.
  - RUN, each edge:
    - If Q[0]=1: {carry,A} = A+M (WIDTH+1-bit sum). Otherwise {carry,A} = {0,A}.
    - Then {carry,A,Q} is shifted right by 1, inserting 0 at the MSB.
    - count<=count+1.
    - On the edge where count=WIDTH-1: product<={A',Q'} (post-shift values) and go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start sampled at edge t0 -> busy=1 after t0 -> product and done=1 after edge t0+WIDTH -> done=0 and IDLE after t0+WIDTH+1.
- Throughput: a new start can be accepted at edge t0+WIDTH+2 at the earliest.
- start while in RUN or DONE: ignored. Operands are not re-captured. a/b may change freely after the accepted edge.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.
- product changes only on the final RUN edge or on reset. It is stable in IDLE and DONE.
- Arithmetic: the intermediate add carries into bit WIDTH, so no overflow is possible. product is the exact unsigned 2*WIDTH result.
- Boundaries: a=0 or b=0 -> product=0. Maximum operands give the full-width product. Counter wrap is never reached because the FSM exits at WIDTH-1.

Optional Feature:
- Macro: SIGNED_MULT_EN.
- Defined: operands are two's complement.
  - On capture, M<=|a| and Q<=|b|. sign<=a[MSB]^b[MSB] is stored in a flag register, reset value 0.
  - On the final RUN edge, product<=sign ? -{A',Q'} : {A',Q'} (2*WIDTH two's-complement negate).
  - |-2^(WIDTH-1)| is treated as unsigned 2^(WIDTH-1).
  - Latency is unchanged.
- Undefined: unsigned only. The sign flag and negation logic are absent.

Test Plan:
- Reset, then a=13, b=11, start pulse at t0 -> busy=1 during t0+1..t0+8, done=1 after t0+8, product=16'h008F, then IDLE.
- a=255, b=255 -> product=16'hFE01. a=0, b=200 -> 16'h0000. a=1, b=128 -> 16'h0080.
- start=1 held and a/b toggled every cycle during RUN -> result uses the operands from t0 only. Second operation begins at t0+10.
- Assert rst_n=0 mid-RUN (count=4, prior product=16'h008F) -> product=0, busy=0, done=0 at once; no done pulse. A new start after release works normally.
- product stability: after a done pulse, hold start=0 for 20 cycles -> product unchanged, done=0.
- SIGNED_MULT_EN: a=8'hFD (-3), b=5 -> 16'hFFF1. a=8'h80, b=8'h80 -> 16'h4000. a=7, b=8'hFF -> 16'hFFF9.
